write_back: RTL and testbench
=============================

WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 Parameters: DWIDTH=32 (data width); AWIDTH=5 (register address width); PC_WIDTH=32 (PC width); FUNCT_WIDTH=3 (funct3 width).
REQ-002 wb_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 wb_rst  in  1  reset, asynchronous, active-low.
REQ-004 wb_i_funct  in  FUNCT_WIDTH  funct3 of the instruction.
REQ-005 wb_i_opcode  in  OPCODE_WIDTH  one-hot opcode class from the shared header: OPCODE_WIDTH=11; bit0 RTYPE, 1 ITYPE, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 10 FENCE.
REQ-006 wb_i_data_load  in  DWIDTH  right-aligned load data from the memory stage.
REQ-007 wb_i_csr  in  DWIDTH  CSR read value, or trap/return target for SYSTEM funct3=0.
REQ-008 wb_i_we_rd / wb_o_we_rd  in/out  1  register-file write enable.
REQ-009 wb_i_we / wb_o_we  in/out  1  generic write-enable pass-through.
REQ-010 wb_i_rd_addr / wb_o_rd_addr  in/out  AWIDTH  destination register.
REQ-011 wb_i_rd_data  in  DWIDTH  ALU result.
REQ-012 wb_o_rd_data  out  DWIDTH  selected write-back data.
REQ-013 wb_i_pc  in  PC_WIDTH  PC of the instruction.
REQ-014 wb_o_next_pc  out  PC_WIDTH  next PC; wb_o_change_pc  out  1  PC redirect strobe.
REQ-015 wb_i_ce / wb_o_ce  in/out  1  stage valid.
REQ-016 wb_i_stall / wb_o_stall, wb_i_flush / wb_o_flush  in/out  1  pipeline control.

Function
REQ-017 Priority at each rising edge: flush, then stall, then normal update.
REQ-018 Flush: wb_o_we_rd, wb_o_we, wb_o_change_pc, wb_o_ce <= 0; all other registers hold.
REQ-019 Stall (no flush): every registered output holds.
REQ-020 Normal, wb_i_ce=0: wb_o_ce, wb_o_we_rd, wb_o_we, wb_o_change_pc <= 0; data, address and PC outputs hold.
REQ-021 Normal, wb_i_ce=1: wb_o_ce<=1; wb_o_we<=wb_i_we; wb_o_rd_addr<=wb_i_rd_addr; wb_o_rd_data<=selected data; one-cycle latency.
REQ-022 Data select: LOAD -> load-extracted data; SYSTEM with funct3≠0 -> wb_i_csr; all other opcodes -> wb_i_rd_data.
REQ-023 Load extraction by funct3: 0 LB sign-extends [7:0]; 1 LH sign-extends [15:0]; 2 LW full word; 4 LBU zero-extends [7:0]; 5 LHU zero-extends [15:0]; other codes full word.
REQ-024 Trap/return: SYSTEM with funct3=0 and ce=1 -> wb_o_change_pc<=1, wb_o_next_pc<=wb_i_csr, wb_o_we_rd<=0.
REQ-025 Any other ce=1 instruction: wb_o_change_pc<=0; wb_o_next_pc<=wb_i_pc+4, modulo 2^PC_WIDTH; wb_o_we_rd<=wb_i_we_rd.
REQ-026 wb_o_stall = wb_i_stall (combinational).
REQ-027 wb_o_flush = wb_i_flush OR registered wb_o_change_pc (combinational).

Reset
REQ-028 While wb_rst=0, all registered outputs are 0, asynchronously, regardless of clock.
REQ-029 Reset released mid-operation: the first rising edge after release performs a normal update.

Configuration
REQ-030 Macro WB_LOAD_EXT_EN. Defined: load extraction per REQ-023. Undefined: LOAD selects wb_i_data_load unmodified for every funct3.

Verification
REQ-031 Reset held 2 cycles -> all outputs 0; stall=0; flush=0.
REQ-032 ce=1, we=1, we_rd=1, LOAD, funct3=0, rd_addr=10, data_load=0xDEADBEEF -> next edge: we_rd=1, we=1, rd_addr=10, rd_data=0xFFFFFFEF, next_pc=pc+4, change_pc=0, ce=1. Macro undefined -> rd_data=0xDEADBEEF.
REQ-033 LOAD with funct3=4, then 5, data_load=0xDEADBEEF -> rd_data 0x000000EF, then 0x0000BEEF.
REQ-034 SYSTEM funct3=0, csr=0x80 -> change_pc=1, next_pc=0x80, we_rd=0, flush=1; next cycle with ce=0 -> change_pc=0, flush=0.
REQ-035 Stall asserted with changed inputs -> outputs hold, stall=1. Flush asserted -> we_rd=we=ce=0 next edge.
REQ-036 ce dropped to 0 -> next edge: we_rd=0, we=0, change_pc=0, ce=0; stall=0, flush=0.

Source files
------------

// File: rtl/write_back.sv
// Write-back stage: selects load/CSR/ALU data for the register file and computes the next PC.
// Optional macro WB_LOAD_EXT_EN enables funct3-based load extraction; otherwise load data passes unmodified.
module write_back #(
    parameter int DWIDTH       = 32,
    parameter int AWIDTH       = 5,
    parameter int PC_WIDTH     = 32,
    parameter int FUNCT_WIDTH  = 3,
    parameter int OPCODE_WIDTH = 11
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst,
    input  logic [FUNCT_WIDTH-1:0]  wb_i_funct,
    input  logic [OPCODE_WIDTH-1:0] wb_i_opcode,
    input  logic [DWIDTH-1:0]       wb_i_data_load,
    input  logic [DWIDTH-1:0]       wb_i_csr,
    input  logic                    wb_i_we_rd,
    output logic                    wb_o_we_rd,
    input  logic                    wb_i_we,
    output logic                    wb_o_we,
    input  logic [AWIDTH-1:0]       wb_i_rd_addr,
    output logic [AWIDTH-1:0]       wb_o_rd_addr,
    input  logic [DWIDTH-1:0]       wb_i_rd_data,
    output logic [DWIDTH-1:0]       wb_o_rd_data,
    input  logic [PC_WIDTH-1:0]     wb_i_pc,
    output logic [PC_WIDTH-1:0]     wb_o_next_pc,
    output logic                    wb_o_change_pc,
    input  logic                    wb_i_ce,
    output logic                    wb_o_ce,
    input  logic                    wb_i_stall,
    output logic                    wb_o_stall,
    input  logic                    wb_i_flush,
    output logic                    wb_o_flush
);

    localparam int OP_LOAD   = 2;
    localparam int OP_SYSTEM = 9;

    logic                    r_we_rd;
    logic                    r_we;
    logic [AWIDTH-1:0]       r_rd_addr;
    logic [DWIDTH-1:0]       r_rd_data;
    logic [PC_WIDTH-1:0]     r_next_pc;
    logic                    r_change_pc;
    logic                    r_ce;

    logic [DWIDTH-1:0]       w_load_data;
    logic [DWIDTH-1:0]       w_sel_data;
    logic                    w_is_load;
    logic                    w_is_system;
    logic                    w_funct_zero;
    logic                    w_is_trap;
    logic                    w_unused_opcode;

    assign w_is_load       = wb_i_opcode[OP_LOAD];
    assign w_is_system     = wb_i_opcode[OP_SYSTEM];
    assign w_funct_zero    = (wb_i_funct == FUNCT_WIDTH'(0));
    // SYSTEM with funct3 zero is a trap entry or return: redirect to the CSR-supplied target.
    assign w_is_trap       = w_is_system && w_funct_zero;
    assign w_unused_opcode = ^{wb_i_opcode[10], wb_i_opcode[8:3], wb_i_opcode[1:0]};

`ifdef WB_LOAD_EXT_EN
    always_comb begin
        w_load_data = wb_i_data_load;
        case (wb_i_funct)
            FUNCT_WIDTH'(0): w_load_data = {{(DWIDTH-8){wb_i_data_load[7]}}, wb_i_data_load[7:0]};
            FUNCT_WIDTH'(1): w_load_data = {{(DWIDTH-16){wb_i_data_load[15]}}, wb_i_data_load[15:0]};
            FUNCT_WIDTH'(4): w_load_data = {{(DWIDTH-8){1'b0}}, wb_i_data_load[7:0]};
            FUNCT_WIDTH'(5): w_load_data = {{(DWIDTH-16){1'b0}}, wb_i_data_load[15:0]};
            default:         w_load_data = wb_i_data_load;
        endcase
    end
`else
    assign w_load_data = wb_i_data_load;
`endif

    always_comb begin
        w_sel_data = wb_i_rd_data;
        if (w_is_load) begin
            w_sel_data = w_load_data;
        end else if (w_is_system && !w_funct_zero) begin
            w_sel_data = wb_i_csr;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_we_rd     <= 1'b0;
            r_we        <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
            r_next_pc   <= '0;
            r_change_pc <= 1'b0;
            r_ce        <= 1'b0;
        end else if (wb_i_flush) begin
            r_we_rd     <= 1'b0;
            r_we        <= 1'b0;
            r_change_pc <= 1'b0;
            r_ce        <= 1'b0;
        end else if (wb_i_stall) begin
            r_ce        <= r_ce;
        end else if (!wb_i_ce) begin
            r_we_rd     <= 1'b0;
            r_we        <= 1'b0;
            r_change_pc <= 1'b0;
            r_ce        <= 1'b0;
        end else begin
            r_ce      <= 1'b1;
            r_we      <= wb_i_we;
            r_rd_addr <= wb_i_rd_addr;
            r_rd_data <= w_sel_data;
            if (w_is_trap) begin
                r_change_pc <= 1'b1;
                r_next_pc   <= wb_i_csr[PC_WIDTH-1:0];
                r_we_rd     <= 1'b0;
            end else begin
                r_change_pc <= 1'b0;
                r_next_pc   <= wb_i_pc + PC_WIDTH'(4);
                r_we_rd     <= wb_i_we_rd;
            end
        end
    end

    assign wb_o_we_rd     = r_we_rd;
    assign wb_o_we        = r_we;
    assign wb_o_rd_addr   = r_rd_addr;
    assign wb_o_rd_data   = r_rd_data;
    assign wb_o_next_pc   = r_next_pc;
    assign wb_o_change_pc = r_change_pc;
    assign wb_o_ce        = r_ce;
    assign wb_o_stall     = wb_i_stall;
    // A taken redirect flushes the earlier stages on the following cycle.
    assign wb_o_flush     = wb_i_flush | r_change_pc;

endmodule

// File: tb/tb_write_back.sv
// Directed testbench for write_back: reset, load extraction, CSR select, trap redirect,
// stall/flush priority, ce drop, PC wrap and asynchronous reset.
module tb_write_back;

    localparam logic [10:0] OP_RTYPE  = 11'b000_0000_0001;
    localparam logic [10:0] OP_LOAD   = 11'b000_0000_0100;
    localparam logic [10:0] OP_SYSTEM = 11'b010_0000_0000;

`ifdef WB_LOAD_EXT_EN
    localparam logic [31:0] EXP_LB  = 32'hFFFF_FFEF;
    localparam logic [31:0] EXP_LBU = 32'h0000_00EF;
    localparam logic [31:0] EXP_LHU = 32'h0000_BEEF;
    localparam logic [31:0] EXP_LH  = 32'hFFFF_BEEF;
`else
    localparam logic [31:0] EXP_LB  = 32'hDEAD_BEEF;
    localparam logic [31:0] EXP_LBU = 32'hDEAD_BEEF;
    localparam logic [31:0] EXP_LHU = 32'hDEAD_BEEF;
    localparam logic [31:0] EXP_LH  = 32'hDEAD_BEEF;
`endif

    logic        wb_clk;
    logic        wb_rst;
    logic [2:0]  wb_i_funct;
    logic [10:0] wb_i_opcode;
    logic [31:0] wb_i_data_load;
    logic [31:0] wb_i_csr;
    logic        wb_i_we_rd;
    logic        wb_o_we_rd;
    logic        wb_i_we;
    logic        wb_o_we;
    logic [4:0]  wb_i_rd_addr;
    logic [4:0]  wb_o_rd_addr;
    logic [31:0] wb_i_rd_data;
    logic [31:0] wb_o_rd_data;
    logic [31:0] wb_i_pc;
    logic [31:0] wb_o_next_pc;
    logic        wb_o_change_pc;
    logic        wb_i_ce;
    logic        wb_o_ce;
    logic        wb_i_stall;
    logic        wb_o_stall;
    logic        wb_i_flush;
    logic        wb_o_flush;

    int n_tests = 0;
    int n_fail  = 0;

    write_back dut (
        .wb_clk         (wb_clk),
        .wb_rst         (wb_rst),
        .wb_i_funct     (wb_i_funct),
        .wb_i_opcode    (wb_i_opcode),
        .wb_i_data_load (wb_i_data_load),
        .wb_i_csr       (wb_i_csr),
        .wb_i_we_rd     (wb_i_we_rd),
        .wb_o_we_rd     (wb_o_we_rd),
        .wb_i_we        (wb_i_we),
        .wb_o_we        (wb_o_we),
        .wb_i_rd_addr   (wb_i_rd_addr),
        .wb_o_rd_addr   (wb_o_rd_addr),
        .wb_i_rd_data   (wb_i_rd_data),
        .wb_o_rd_data   (wb_o_rd_data),
        .wb_i_pc        (wb_i_pc),
        .wb_o_next_pc   (wb_o_next_pc),
        .wb_o_change_pc (wb_o_change_pc),
        .wb_i_ce        (wb_i_ce),
        .wb_o_ce        (wb_o_ce),
        .wb_i_stall     (wb_i_stall),
        .wb_o_stall     (wb_o_stall),
        .wb_i_flush     (wb_i_flush),
        .wb_o_flush     (wb_o_flush)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string step, input logic we_rd, input logic we,
                           input logic [4:0] addr, input logic [31:0] data,
                           input logic [31:0] npc, input logic chg, input logic ce,
                           input logic stall, input logic flush);
        chk({step, ".we_rd"},     {31'd0, wb_o_we_rd},     {31'd0, we_rd});
        chk({step, ".we"},        {31'd0, wb_o_we},        {31'd0, we});
        chk({step, ".rd_addr"},   {27'd0, wb_o_rd_addr},   {27'd0, addr});
        chk({step, ".rd_data"},   wb_o_rd_data,            data);
        chk({step, ".next_pc"},   wb_o_next_pc,            npc);
        chk({step, ".change_pc"}, {31'd0, wb_o_change_pc}, {31'd0, chg});
        chk({step, ".ce"},        {31'd0, wb_o_ce},        {31'd0, ce});
        chk({step, ".stall"},     {31'd0, wb_o_stall},     {31'd0, stall});
        chk({step, ".flush"},     {31'd0, wb_o_flush},     {31'd0, flush});
    endtask

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic drive(input logic ce, input logic [10:0] op, input logic [2:0] f,
                         input logic we, input logic we_rd, input logic [4:0] addr,
                         input logic [31:0] rd_data, input logic [31:0] load,
                         input logic [31:0] csr, input logic [31:0] pc);
        wb_i_ce        = ce;
        wb_i_opcode    = op;
        wb_i_funct     = f;
        wb_i_we        = we;
        wb_i_we_rd     = we_rd;
        wb_i_rd_addr   = addr;
        wb_i_rd_data   = rd_data;
        wb_i_data_load = load;
        wb_i_csr       = csr;
        wb_i_pc        = pc;
    endtask

    initial begin
        wb_rst     = 1'b0;
        wb_i_stall = 1'b0;
        wb_i_flush = 1'b0;
        drive(1'b0, 11'd0, 3'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Reset held for two cycles
        step();
        step();
        chk_all("reset", 0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        wb_rst = 1'b1;

        // Loads of 0xDEADBEEF with each extraction code
        drive(1'b1, OP_LOAD, 3'd0, 1'b1, 1'b1, 5'd10, 32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h100);
        step();
        chk_all("lb", 1, 1, 5'd10, EXP_LB, 32'h104, 0, 1, 0, 0);
        wb_i_funct = 3'd4;
        step();
        chk_all("lbu", 1, 1, 5'd10, EXP_LBU, 32'h104, 0, 1, 0, 0);
        wb_i_funct = 3'd5;
        step();
        chk_all("lhu", 1, 1, 5'd10, EXP_LHU, 32'h104, 0, 1, 0, 0);
        wb_i_funct = 3'd1;
        step();
        chk_all("lh", 1, 1, 5'd10, EXP_LH, 32'h104, 0, 1, 0, 0);
        wb_i_funct = 3'd2;
        step();
        chk_all("lw", 1, 1, 5'd10, 32'hDEAD_BEEF, 32'h104, 0, 1, 0, 0);

        // CSR read selects the CSR value
        drive(1'b1, OP_SYSTEM, 3'd2, 1'b1, 1'b1, 5'd3, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0000_1234, 32'h200);
        step();
        chk_all("csrr", 1, 1, 5'd3, 32'h0000_1234, 32'h204, 0, 1, 0, 0);

        // Trap/return redirects to CSR target, suppresses register write
        drive(1'b1, OP_SYSTEM, 3'd0, 1'b1, 1'b1, 5'd3, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0000_0080, 32'h300);
        step();
        chk_all("trap", 0, 1, 5'd3, 32'h1111_1111, 32'h80, 1, 1, 0, 1);

        // ce dropped: strobes clear, data/addr/pc hold
        drive(1'b0, OP_RTYPE, 3'd0, 1'b1, 1'b1, 5'd7, 32'h5555_5555, 32'd0, 32'd0, 32'h500);
        step();
        chk_all("ce_off", 0, 0, 5'd3, 32'h1111_1111, 32'h80, 0, 0, 0, 0);

        // ALU result with PC wraparound
        drive(1'b1, OP_RTYPE, 3'd0, 1'b0, 1'b1, 5'd5, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h999, 32'hFFFF_FFFC);
        step();
        chk_all("rtype_wrap", 1, 0, 5'd5, 32'hCAFE_F00D, 32'h0, 0, 1, 0, 0);

        // Stall with changed inputs (including a trap): everything holds
        wb_i_stall = 1'b1;
        drive(1'b1, OP_SYSTEM, 3'd0, 1'b1, 1'b0, 5'd9, 32'h1234_5678, 32'd0, 32'h0000_0999, 32'h40);
        step();
        chk_all("stall", 1, 0, 5'd5, 32'hCAFE_F00D, 32'h0, 0, 1, 1, 0);

        // Flush wins over stall
        wb_i_flush = 1'b1;
        step();
        chk_all("flush_stall", 0, 0, 5'd5, 32'hCAFE_F00D, 32'h0, 0, 0, 1, 1);

        // Flush alone with a valid instruction: strobes clear, data holds
        wb_i_stall = 1'b0;
        drive(1'b1, OP_RTYPE, 3'd0, 1'b1, 1'b1, 5'd9, 32'h1234_5678, 32'd0, 32'd0, 32'h40);
        step();
        chk_all("flush", 0, 0, 5'd5, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 1);

        wb_i_flush = 1'b0;
        step();
        chk_all("resume", 1, 1, 5'd9, 32'h1234_5678, 32'h44, 0, 1, 0, 0);

        wb_i_ce = 1'b0;
        step();
        chk_all("ce_drop", 0, 0, 5'd9, 32'h1234_5678, 32'h44, 0, 0, 0, 0);

        // Asynchronous reset between edges
        drive(1'b1, OP_RTYPE, 3'd0, 1'b1, 1'b1, 5'd12, 32'hA5A5_A5A5, 32'd0, 32'd0, 32'h1000);
        step();
        chk_all("pre_rst", 1, 1, 5'd12, 32'hA5A5_A5A5, 32'h1004, 0, 1, 0, 0);
        #1;
        wb_rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        step();
        chk_all("rst_held", 0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        wb_rst = 1'b1;
        step();
        chk_all("post_rst", 1, 1, 5'd12, 32'hA5A5_A5A5, 32'h1004, 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
